// File: rtl/arg_mailbox_reader.sv
// Argument mailbox: valid/ready writer into a DEPTH-entry circular FIFO, request/response reader.
// Define ARG_MAILBOX_READER_STICKY_ERR_EN to make rd_err latch until the next accepted read.
module arg_mailbox_reader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_req,
    output logic                     rd_valid,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_err,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_acc;
    logic             rd_acc;
    logic             rd_empty;
    logic [CW-1:0]    count_nxt;

    // wr_ready decodes registered occupancy only, so a same-cycle read never opens a slot early.
    assign wr_ready = (count != CW'(DEPTH));
    assign wr_acc   = wr_valid && wr_ready;
    assign rd_acc   = rd_req && (count != '0);
    assign rd_empty = rd_req && (count == '0);

    always_comb begin
        count_nxt = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Storage is intentionally not reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            count    <= count_nxt;
            rd_valid <= rd_acc;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
        end
    end

`ifdef ARG_MAILBOX_READER_STICKY_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_err <= 1'b0;
        end else if (rd_acc) begin
            rd_err <= 1'b0;
        end else if (rd_empty) begin
            rd_err <= 1'b1;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_err <= 1'b0;
        end else begin
            rd_err <= rd_empty;
        end
    end
`endif

endmodule

// File: tb/tb_arg_mailbox_reader.sv
// Self-checking bench for arg_mailbox_reader: directed scenarios plus random traffic vs a queue model.
// Honours ARG_MAILBOX_READER_STICKY_ERR_EN for the expected rd_err behaviour.
module tb_arg_mailbox_reader;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst_n;
    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] wr_data;
    logic             rd_req;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic             rd_err;
    logic [$clog2(DEPTH):0] count;

    arg_mailbox_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .rd_req   (rd_req),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_err   (rd_err),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int failed;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_data;
    logic             m_err;
    logic             m_vld;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of traffic; called at posedge+1, returns at the following posedge+1.
    task automatic step(input logic wv, input logic [WIDTH-1:0] wd, input logic rr);
        bit was_empty;
        bit was_full;
        wr_valid = wv;
        wr_data  = wd;
        rd_req   = rr;
        #2;
        was_empty = (q.size() == 0);
        was_full  = (q.size() == DEPTH);
        check("wr_ready", {31'd0, wr_ready}, {31'd0, !was_full});
        m_vld = 1'b0;
        if (rr && !was_empty) begin
            m_data = q.pop_front();
            m_vld  = 1'b1;
        end
`ifdef ARG_MAILBOX_READER_STICKY_ERR_EN
        if (m_vld) m_err = 1'b0;
        else if (rr && was_empty) m_err = 1'b1;
`else
        m_err = rr && was_empty;
`endif
        if (wv && !was_full) q.push_back(wd);
        @(posedge clk);
        #1;
        check("rd_valid", {31'd0, rd_valid}, {31'd0, m_vld});
        check("rd_data", {24'd0, rd_data}, {24'd0, m_data});
        check("rd_err", {31'd0, rd_err}, {31'd0, m_err});
        check("count", {29'd0, count}, q.size());
        wr_valid = 1'b0;
        rd_req   = 1'b0;
    endtask

    logic [WIDTH-1:0] fill_vals [4];

    initial begin
        tests    = 0;
        failed   = 0;
        m_data   = '0;
        m_err    = 1'b0;
        m_vld    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_req   = 1'b0;
        rst_n    = 1'b0;
        fill_vals[0] = 8'h11;
        fill_vals[1] = 8'h22;
        fill_vals[2] = 8'h33;
        fill_vals[3] = 8'h44;

        repeat (3) @(posedge clk);
        #1;
        check("reset_count", {29'd0, count}, 32'd0);
        check("reset_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("reset_rd_data", {24'd0, rd_data}, 32'd0);
        check("reset_rd_err", {31'd0, rd_err}, 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Mid-stream asynchronous reset
        step(1'b1, 8'h3C, 1'b0);
        step(1'b1, 8'h5A, 1'b0);
        step(1'b1, 8'h7E, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_count", {29'd0, count}, 32'd0);
        check("async_rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("async_rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("async_rst_rd_data", {24'd0, rd_data}, 32'd0);
        check("async_rst_rd_err", {31'd0, rd_err}, 32'd0);
        q.delete();
        m_data = '0;
        m_err  = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, 8'h00, 1'b1);
        check("post_rst_empty_err", {31'd0, rd_err}, 32'd1);

        // Fill to full, overflow write dropped, then drain back-to-back
        for (int i = 0; i < 4; i++) step(1'b1, fill_vals[i], 1'b0);
        step(1'b1, 8'h55, 1'b0);
        check("full_count", {29'd0, count}, 32'd4);
        check("full_wr_ready", {31'd0, wr_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b1);
            check("drain_data", {24'd0, rd_data}, {24'd0, fill_vals[i]});
        end
        check("drained_count", {29'd0, count}, 32'd0);

        // Empty read with simultaneous write
        step(1'b1, 8'hA5, 1'b1);
        check("empty_wr_rd_err", {31'd0, rd_err}, 32'd1);
        check("empty_wr_rd_count", {29'd0, count}, 32'd1);
        step(1'b0, 8'h00, 1'b1);
        check("empty_wr_readback", {24'd0, rd_data}, 32'hA5);

        // Full with concurrent read and write
        for (int i = 1; i <= 4; i++) step(1'b1, WIDTH'(i), 1'b0);
        step(1'b1, 8'h66, 1'b1);
        check("full_rw_data", {24'd0, rd_data}, 32'h01);
        check("full_rw_count", {29'd0, count}, 32'd3);
        check("full_rw_ready_next", {31'd0, wr_ready}, 32'd1);
        repeat (3) step(1'b0, 8'h00, 1'b1);

        // Wrap-around at steady occupancy of one
        step(1'b1, 8'd0, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            step(1'b1, WIDTH'(i), 1'b1);
            check("wrap_data", {24'd0, rd_data}, i - 1);
        end
        step(1'b0, 8'h00, 1'b1);
        check("wrap_last", {24'd0, rd_data}, 32'd9);

        // Error mode
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h0F, 1'b0);
`ifdef ARG_MAILBOX_READER_STICKY_ERR_EN
        check("sticky_hold", {31'd0, rd_err}, 32'd1);
`else
        check("pulse_clear", {31'd0, rd_err}, 32'd0);
`endif
        step(1'b0, 8'h00, 1'b1);
        check("err_mode_data", {24'd0, rd_data}, 32'h0F);
        check("err_mode_clear", {31'd0, rd_err}, 32'd0);

        // Random traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
